// File: rtl/addsub_share_arb.sv
// Shared 16-bit add/sub unit: round-robin arbitration across NUM_REQ requesters, tagged Z/V/N results.
// Latency: grant and operand sampling in the same cycle; result on rsp_* the next cycle when the FIFO is empty.
// Backpressure: 2-entry output FIFO; grants stop while it holds 2 entries (registered count, no rsp_ready path).
//
// Ports: clk/rst_n (async active-low); req_valid/req_a/req_b/req_sub per requester (16-bit lanes packed
//        low-to-high by index); req_grant one-hot accept; rsp_valid/rsp_ready handshake on the FIFO head
//        with rsp_id, rsp_sum, rsp_ovfl (V), rsp_zero (Z), rsp_neg (N).
// Optional: define ADDSUB_SAT_EN to clamp overflowed results to 0x7FFF / 0x8000 (V is still reported).

// Two-entry in-order FIFO with 1-bit pointers. When empty, the output holds the most recently
// popped entry, so downstream sees a stable value instead of stale storage.
module addsub_share_arb_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push_vld,
    input  logic [W-1:0] i_push_dat,
    output logic         o_pop_vld,
    input  logic         i_pop_rdy,
    output logic [W-1:0] o_pop_dat,
    output logic [1:0]   o_count
);
    logic [W-1:0] r_mem [2];
    logic [W-1:0] r_hold;
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign w_pop  = (r_count != 2'd0) && i_pop_rdy;
    assign w_push = i_push_vld && (r_count != 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_hold   <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_hold   <= r_mem[r_rd_ptr];
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_pop_vld = (r_count != 2'd0);
    assign o_pop_dat = (r_count != 2'd0) ? r_mem[r_rd_ptr] : r_hold;
    assign o_count   = r_count;
endmodule

module addsub_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*16-1:0] req_a,
    input  logic [NUM_REQ*16-1:0] req_b,
    input  logic [NUM_REQ-1:0]    req_sub,
    output logic [NUM_REQ-1:0]    req_grant,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [15:0]           rsp_sum,
    output logic                  rsp_ovfl,
    output logic                  rsp_zero,
    output logic                  rsp_neg
);
    typedef struct packed {
        logic [IDW-1:0] id;
        logic [15:0]    sum;
        logic           ovfl;
        logic           zero;
        logic           neg;
    } rsp_t;

    logic [IDW-1:0] r_ptr;
    logic [1:0]     w_count;
    logic           w_space;
    logic           w_found;
    logic           w_gnt_any;
    logic [IDW-1:0] w_gnt_idx;
    logic [15:0]    w_a;
    logic [15:0]    w_b;
    logic           w_sub;
    logic [15:0]    w_b_eff;
    logic [15:0]    w_sum;
    logic [15:0]    w_res;
    logic           w_v;
    rsp_t           w_push_dat;
    rsp_t           w_head;

    // Space comes from the registered count only, keeping rsp_ready out of the grant path.
    assign w_space = (w_count < 2'd2);

    // Round-robin pick: rank each valid requester by its distance past the pointer,
    // the nearest one (starting at ptr+1) wins.
    always_comb begin
        int best_d;
        int d;
        best_d    = NUM_REQ;
        d         = 0;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = i - int'(r_ptr) - 1;
            if (d < 0) begin
                d = d + NUM_REQ;
            end
            if (req_valid[i] && (d < best_d)) begin
                best_d    = d;
                w_found   = 1'b1;
                w_gnt_idx = IDW'(i);
            end
        end
    end

    // rst_n gating keeps grants low for the whole reset window, not just after the first edge.
    assign w_gnt_any = w_found && w_space && rst_n;

    always_comb begin
        req_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_grant[i] = w_gnt_any && (w_gnt_idx == IDW'(i));
        end
    end

    // Operand mux feeding the single shared adder.
    always_comb begin
        w_a   = '0;
        w_b   = '0;
        w_sub = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == IDW'(i)) begin
                w_a   = req_a[16*i +: 16];
                w_b   = req_b[16*i +: 16];
                w_sub = req_sub[i];
            end
        end
    end

    // Subtract is A + ~B + 1; the carry-in reuses the sub bit.
    assign w_b_eff = w_sub ? ~w_b : w_b;
    assign w_sum   = w_a + w_b_eff + {15'd0, w_sub};
    assign w_v     = w_sub ? ((w_a[15] != w_b[15]) && (w_sum[15] != w_a[15]))
                           : ((w_a[15] == w_b[15]) && (w_sum[15] != w_a[15]));

`ifdef ADDSUB_SAT_EN
    // Overflow direction follows A's sign: positive A can only overflow upward.
    assign w_res = w_v ? (w_a[15] ? 16'h8000 : 16'h7FFF) : w_sum;
`else
    assign w_res = w_sum;
`endif

    always_comb begin
        w_push_dat      = '0;
        w_push_dat.id   = w_gnt_idx;
        w_push_dat.sum  = w_res;
        w_push_dat.ovfl = w_v;
        w_push_dat.zero = (w_res == 16'd0);
        w_push_dat.neg  = w_res[15];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= IDW'(NUM_REQ - 1);
        end else if (w_gnt_any) begin
            r_ptr <= w_gnt_idx;
        end
    end

    addsub_share_arb_fifo2 #(
        .W($bits(rsp_t))
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push_vld (w_gnt_any),
        .i_push_dat (w_push_dat),
        .o_pop_vld  (rsp_valid),
        .i_pop_rdy  (rsp_ready),
        .o_pop_dat  (w_head),
        .o_count    (w_count)
    );

    assign rsp_id   = w_head.id;
    assign rsp_sum  = w_head.sum;
    assign rsp_ovfl = w_head.ovfl;
    assign rsp_zero = w_head.zero;
    assign rsp_neg  = w_head.neg;
endmodule
